dte_ebus_diag_seq: RTL and testbench

- Cycle-timed EBUS diagnostic sequencer, directly downstream of the DTE request executor.
- Accepts one DTE transaction at a time: read, write, diag function or release.
- Drives the EBUS diagnostic select, the strobe and the DTE data driver with programmed setup, strobe and hold timing.
- Samples EBUS data and returns a 36-bit reply through a valid/ready handshake.

---
 rtl/dte_ebus_diag_seq.sv | 208 ++++++++++++++++++++
 tb/tb_dte_ebus_diag_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dte_ebus_diag_seq.sv
// EBUS diagnostic sequencer sitting behind the DTE request executor.
// Takes one DTE transaction at a time (read, write, diag function, release),
// drives the EBUS diag select, strobe and DTE data driver with programmed
// setup/strobe/hold timing, samples the bus and returns a 36-bit reply.
// Data words use PDP-10 bit numbering: bit 0 is the MSB.
module dte_ebus_diag_seq #(
  parameter int SETUP_TICKS  = 2,
  parameter int STROBE_TICKS = 4,
  parameter int HOLD_TICKS   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [6:0]  req_func,
  input  logic [0:35] req_data,
  output logic [6:0]  ebus_ds,
  output logic        ebus_diag_strobe,
  output logic        ebus_driving,
  output logic [0:35] ebus_data_out,
  input  logic [0:35] ebus_data_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:35] rsp_data,
  output logic        busy
);

  localparam int DATA_W = 36;
  localparam int FUNC_W = 7;
  localparam int CNT_W  = 4;

  // Counter load values: each phase counts N-1 down to 0, i.e. N cycles.
  localparam int HOLD_M1 = (HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0;
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_TICKS - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_M1);

  localparam logic [1:0] TYPE_READ    = 2'd0;
  localparam logic [1:0] TYPE_WRITE   = 2'd1;
  localparam logic [1:0] TYPE_DIAG    = 2'd2;
  localparam logic [1:0] TYPE_RELEASE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_REPLY
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic [FUNC_W-1:0]   ds_q, ds_d;
  logic                strobe_q, strobe_d;
  logic                driving_q, driving_d;
  logic [0:DATA_W-1]   dout_q, dout_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [0:DATA_W-1]   rsp_data_q, rsp_data_d;

  // Next-state and next-output logic for the whole sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    ds_d        = ds_q;
    strobe_d    = strobe_q;
    driving_d   = driving_q;
    dout_d      = dout_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        // req_ready_q is high exactly while idle, so it doubles as the accept qualifier.
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          case (req_type)
            TYPE_READ: begin
              rsp_data_d  = ebus_data_in;
              rsp_valid_d = 1'b1;
              state_d     = ST_REPLY;
            end
            TYPE_WRITE: begin
              ds_d      = req_func;
              dout_d    = req_data;
              driving_d = 1'b1;
              cnt_d     = SETUP_LOAD;
              state_d   = ST_SETUP;
            end
            TYPE_DIAG: begin
              // Diag function strobes the select only; the driver keeps its state.
              ds_d    = req_func;
              cnt_d   = SETUP_LOAD;
              state_d = ST_SETUP;
            end
            default: begin
              // Release: hand the bus back and report what it now shows.
              driving_d   = 1'b0;
              dout_d      = '0;
              strobe_d    = 1'b0;
              rsp_data_d  = ebus_data_in;
              rsp_valid_d = 1'b1;
              state_d     = ST_REPLY;
            end
          endcase
        end
      end

      ST_SETUP: begin
        if (cnt_q == '0) begin
          strobe_d = 1'b1;
          cnt_d    = STROBE_LOAD;
          state_d  = ST_STROBE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_STROBE: begin
        if (cnt_q == '0) begin
          // Capture the bus during the final strobe-high cycle.
          rsp_data_d = ebus_data_in;
          strobe_d   = 1'b0;
          if (HOLD_TICKS == 0) begin
            rsp_valid_d = 1'b1;
            state_d     = ST_REPLY;
          end else begin
            cnt_d   = HOLD_LOAD;
            state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_HOLD: begin
        // ebus_ds is left untouched here so the select stays stable after strobe.
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          state_d     = ST_REPLY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_REPLY: begin
        // rsp_data is not touched here, so it is stable for the whole reply.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        strobe_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; asynchronous reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      ds_q        <= '0;
      strobe_q    <= 1'b0;
      driving_q   <= 1'b0;
      dout_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      ds_q        <= ds_d;
      strobe_q    <= strobe_d;
      driving_q   <= driving_d;
      dout_q      <= dout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign busy             = busy_q;
  assign ebus_ds          = ds_q;
  assign ebus_diag_strobe = strobe_q;
  assign ebus_driving     = driving_q;
  assign ebus_data_out    = dout_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;

endmodule

// File: tb/tb_dte_ebus_diag_seq.sv
// Bench for dte_ebus_diag_seq: directed scenarios plus randomized transactions
// checked against a transaction-level model of the sequencer.
`timescale 1ns/1ps
module tb_dte_ebus_diag_seq;

  localparam int S  = 2, T  = 4, H  = 2;
  localparam int S2 = 1, T2 = 1, H2 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req_valid, req_ready, ebus_diag_strobe, ebus_driving, rsp_valid, rsp_ready, busy;
  logic [1:0]  req_type;
  logic [6:0]  req_func, ebus_ds;
  logic [0:35] req_data, ebus_data_out, ebus_data_in, rsp_data;

  logic        r2_req_valid, r2_req_ready, r2_strobe, r2_driving, r2_rsp_valid, r2_rsp_ready, r2_busy;
  logic [1:0]  r2_req_type;
  logic [6:0]  r2_req_func, r2_ds;
  logic [0:35] r2_req_data, r2_data_out, r2_data_in, r2_rsp_data;

  dte_ebus_diag_seq #(.SETUP_TICKS(S), .STROBE_TICKS(T), .HOLD_TICKS(H)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_func(req_func), .req_data(req_data),
    .ebus_ds(ebus_ds), .ebus_diag_strobe(ebus_diag_strobe), .ebus_driving(ebus_driving),
    .ebus_data_out(ebus_data_out), .ebus_data_in(ebus_data_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy));

  dte_ebus_diag_seq #(.SETUP_TICKS(S2), .STROBE_TICKS(T2), .HOLD_TICKS(H2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(r2_req_valid), .req_ready(r2_req_ready),
    .req_type(r2_req_type), .req_func(r2_req_func), .req_data(r2_req_data),
    .ebus_ds(r2_ds), .ebus_diag_strobe(r2_strobe), .ebus_driving(r2_driving),
    .ebus_data_out(r2_data_out), .ebus_data_in(r2_data_in),
    .rsp_valid(r2_rsp_valid), .rsp_ready(r2_rsp_ready), .rsp_data(r2_rsp_data), .busy(r2_busy));

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model of the persistent bus-side state.
  logic        m_drv;
  logic [0:35] m_dout;
  logic [6:0]  m_ds;

  // Observations from the last run_txn.
  logic [0:35] bus_hist [0:63];
  int          o_lat, o_stb_cnt, o_stb_first, o_valid_cycles;
  bit          o_unstable, o_rdy_busy, o_ds_moved, o_timeout, o_rdy0;
  logic [6:0]  o_ds1;
  logic        o_drv1, o_busy1, o_post_valid, o_post_ready, o_post_busy;
  logic [0:35] o_rsp, o_dout1;

  function automatic logic [0:35] rnd36();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[35:0];
  endfunction

  function automatic int exp_lat(input logic [1:0] typ);
    return (typ == 2'd1 || typ == 2'd2) ? 1 + S + T + H : 1;
  endfunction

  function automatic logic [0:35] exp_rsp(input logic [1:0] typ);
    return (typ == 2'd1 || typ == 2'd2) ? bus_hist[S + T] : bus_hist[0];
  endfunction

  task automatic model_apply(input logic [1:0] typ, input logic [6:0] func, input logic [0:35] data);
    case (typ)
      2'd1: begin m_ds = func; m_drv = 1'b1; m_dout = data; end
      2'd2: m_ds = func;
      2'd3: begin m_drv = 1'b0; m_dout = '0; end
      default: ;
    endcase
  endtask

  // Runs one transaction on dut and records what was seen; no judging here.
  task automatic run_txn(input logic [1:0] typ, input logic [6:0] func, input logic [0:35] data,
                         input int stall, input bit fix0, input logic [0:35] bus0);
    bit seen, hs, done;
    int vcnt;
    o_lat = -1; o_stb_cnt = 0; o_stb_first = -1; o_valid_cycles = 0;
    o_unstable = 0; o_rdy_busy = 0; o_ds_moved = 0; o_timeout = 0;
    seen = 0; hs = 0; done = 0; vcnt = 0;
    @(negedge clk);
    o_rdy0 = req_ready;
    req_valid = 1'b1; req_type = typ; req_func = func; req_data = data;
    ebus_data_in = fix0 ? bus0 : rnd36();
    bus_hist[0] = ebus_data_in;
    rsp_ready = (stall == 0);
    @(posedge clk);
    for (int j = 1; j < 60 && !done; j++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (hs) begin
        o_post_valid = rsp_valid; o_post_ready = req_ready; o_post_busy = busy;
        done = 1;
      end else begin
        if (j == 1) begin
          o_ds1 = ebus_ds; o_drv1 = ebus_driving; o_dout1 = ebus_data_out; o_busy1 = busy;
        end else if (ebus_ds !== o_ds1) o_ds_moved = 1;
        if (ebus_diag_strobe === 1'b1) begin
          o_stb_cnt++;
          if (o_stb_first < 0) o_stb_first = j;
        end
        if (req_ready !== 1'b0) o_rdy_busy = 1;
        if (rsp_valid === 1'b1) begin
          o_valid_cycles++;
          if (!seen) begin seen = 1; o_lat = j; o_rsp = rsp_data; end
          else if (rsp_data !== o_rsp) o_unstable = 1;
          if (vcnt >= stall) begin rsp_ready = 1'b1; hs = 1; end
          vcnt++;
        end
        ebus_data_in = rnd36();
        bus_hist[j] = ebus_data_in;
      end
    end
    if (!done) o_timeout = 1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_checks++; if ({busy, rsp_valid, ebus_diag_strobe, ebus_driving} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {busy, rsp_valid, ebus_diag_strobe, ebus_driving}); end
    n_checks++; if ({ebus_ds, ebus_data_out, rsp_data} !== 79'b0) begin n_fail++; $display("FAIL reset_data: ds %o dout %o rsp %o want all 0", ebus_ds, ebus_data_out, rsp_data); end
    rst_n = 1'b1;
    m_drv = 1'b0; m_dout = '0; m_ds = '0;
  endtask

  task automatic test_write();
    logic [0:35] d;
    d = 36'o123456654321;
    run_txn(2'd1, 7'o071, d, 0, 1'b0, '0);
    model_apply(2'd1, 7'o071, d);
    n_checks++; if (o_timeout || o_lat !== exp_lat(2'd1)) begin n_fail++; $display("FAIL write_latency: got %0d want %0d", o_lat, exp_lat(2'd1)); end
    n_checks++; if (o_ds1 !== 7'o071 || o_drv1 !== 1'b1 || o_dout1 !== d) begin n_fail++; $display("FAIL write_drive: ds %o drv %b dout %o want 071 1 %o", o_ds1, o_drv1, o_dout1, d); end
    n_checks++; if (o_stb_first !== S + 1 || o_stb_cnt !== T) begin n_fail++; $display("FAIL write_strobe: first %0d width %0d want %0d %0d", o_stb_first, o_stb_cnt, S + 1, T); end
    n_checks++; if (o_rsp !== exp_rsp(2'd1)) begin n_fail++; $display("FAIL write_rsp: got %o want %o", o_rsp, exp_rsp(2'd1)); end
    n_checks++; if (ebus_driving !== 1'b1 || ebus_data_out !== d) begin n_fail++; $display("FAIL write_persist: drv %b dout %o want 1 %o", ebus_driving, ebus_data_out, d); end
    n_checks++; if (o_post_valid !== 1'b0 || o_post_ready !== 1'b1 || o_post_busy !== 1'b0 || o_rdy_busy) begin n_fail++; $display("FAIL write_handshake: valid %b ready %b busy %b rdy_busy %b", o_post_valid, o_post_ready, o_post_busy, o_rdy_busy); end
    n_checks++; if (o_ds_moved) begin n_fail++; $display("FAIL write_ds_stable: ds moved, last %o want %o", ebus_ds, o_ds1); end
  endtask

  task automatic test_read();
    run_txn(2'd0, 7'o155, rnd36(), 0, 1'b1, 36'o777000000777);
    n_checks++; if (o_timeout || o_lat !== 1) begin n_fail++; $display("FAIL read_latency: got %0d want 1", o_lat); end
    n_checks++; if (o_rsp !== 36'o777000000777) begin n_fail++; $display("FAIL read_rsp: got %o want 777000000777", o_rsp); end
    n_checks++; if (o_stb_cnt !== 0) begin n_fail++; $display("FAIL read_strobe: got %0d strobe cycles want 0", o_stb_cnt); end
    n_checks++; if (o_ds1 !== m_ds || o_drv1 !== m_drv || o_dout1 !== m_dout) begin n_fail++; $display("FAIL read_bus_kept: ds %o drv %b dout %o want %o %b %o", o_ds1, o_drv1, o_dout1, m_ds, m_drv, m_dout); end
  endtask

  task automatic test_release();
    run_txn(2'd3, 7'o000, rnd36(), 0, 1'b0, '0);
    model_apply(2'd3, 7'o000, '0);
    n_checks++; if (o_drv1 !== 1'b0 || o_dout1 !== 36'o0) begin n_fail++; $display("FAIL release_drive: drv %b dout %o want 0 0", o_drv1, o_dout1); end
    n_checks++; if (o_timeout || o_lat !== 1 || o_rsp !== bus_hist[0]) begin n_fail++; $display("FAIL release_rsp: lat %0d rsp %o want 1 %o", o_lat, o_rsp, bus_hist[0]); end
  endtask

  task automatic test_diag_stall();
    run_txn(2'd2, 7'o100, rnd36(), 5, 1'b0, '0);
    model_apply(2'd2, 7'o100, '0);
    n_checks++; if (o_timeout || o_lat !== exp_lat(2'd2) || o_rsp !== exp_rsp(2'd2)) begin n_fail++; $display("FAIL diag_reply: lat %0d rsp %o want %0d %o", o_lat, o_rsp, exp_lat(2'd2), exp_rsp(2'd2)); end
    n_checks++; if (o_ds1 !== 7'o100 || o_drv1 !== m_drv) begin n_fail++; $display("FAIL diag_drive: ds %o drv %b want 100 %b", o_ds1, o_drv1, m_drv); end
    n_checks++; if (o_unstable || o_valid_cycles !== 6) begin n_fail++; $display("FAIL diag_stall_hold: unstable %b valid cycles %0d want 0 6", o_unstable, o_valid_cycles); end
    n_checks++; if (o_rdy_busy || o_post_ready !== 1'b1 || o_post_valid !== 1'b0) begin n_fail++; $display("FAIL diag_stall_ready: rdy_busy %b post ready %b post valid %b", o_rdy_busy, o_post_ready, o_post_valid); end
  endtask

  task automatic test_reset_mid_strobe();
    int seen_valid;
    @(negedge clk);
    req_valid = 1'b1; req_type = 2'd1; req_func = 7'o042; req_data = rnd36(); rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (S) @(negedge clk);
    n_checks++; if (ebus_diag_strobe !== 1'b1 || ebus_driving !== 1'b1) begin n_fail++; $display("FAIL rst_pre_strobe: strobe %b drv %b want 1 1", ebus_diag_strobe, ebus_driving); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({ebus_diag_strobe, ebus_driving, rsp_valid, busy} !== 4'b0) begin n_fail++; $display("FAIL rst_async_drop: strobe/drv/valid/busy %b want 0000", {ebus_diag_strobe, ebus_driving, rsp_valid, busy}); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_ready: got %b want 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    m_drv = 1'b0; m_dout = '0; m_ds = '0;
    seen_valid = 0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen_valid++;
    end
    rsp_ready = 1'b0;
    n_checks++; if (seen_valid !== 0) begin n_fail++; $display("FAIL rst_no_reply: got %0d reply cycles want 0", seen_valid); end
    n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || ebus_diag_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_after: ready %b busy %b strobe %b want 1 0 0", req_ready, busy, ebus_diag_strobe); end
  endtask

  // Reads held back-to-back: one reply every two cycles, never double-accepted.
  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1; req_type = 2'd0; req_func = 7'o0; rsp_ready = 1'b1;
    ebus_data_in = rnd36(); bus_hist[0] = ebus_data_in;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      n_checks++; if (req_ready !== ((n % 2) == 0) || rsp_valid !== ((n % 2) == 1)) begin n_fail++; $display("FAIL b2b_cycle%0d: ready %b valid %b want %b %b", n, req_ready, rsp_valid, (n % 2) == 0, (n % 2) == 1); end
      if ((n % 2) == 1) begin
        n_checks++; if (rsp_data !== bus_hist[n - 1]) begin n_fail++; $display("FAIL b2b_rsp%0d: got %o want %o", n, rsp_data, bus_hist[n - 1]); end
      end
      if (n == 8) req_valid = 1'b0;
      ebus_data_in = rnd36(); bus_hist[n] = ebus_data_in;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // A release offered and held during a write is taken only after the write finishes.
  task automatic test_held_during_write();
    int lat;
    logic [0:35] d;
    lat = exp_lat(2'd1);
    d = rnd36();
    @(negedge clk);
    req_valid = 1'b1; req_type = 2'd1; req_func = 7'o013; req_data = d; rsp_ready = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= lat + 2; j++) begin
      @(negedge clk);
      if (j == 1) req_type = 2'd3;
      if (j <= lat + 1) begin
        n_checks++; if (ebus_driving !== 1'b1) begin n_fail++; $display("FAIL held_drv_j%0d: got %b want 1", j, ebus_driving); end
      end
      if (j == lat + 2) begin
        req_valid = 1'b0;
        n_checks++; if (ebus_driving !== 1'b0 || ebus_data_out !== 36'o0 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL held_release: drv %b dout %o valid %b want 0 0 1", ebus_driving, ebus_data_out, rsp_valid); end
      end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    model_apply(2'd1, 7'o013, d);
    model_apply(2'd3, 7'o0, '0);
  endtask

  task automatic test_random();
    logic [1:0]  typ;
    logic [6:0]  fn;
    logic [0:35] d;
    int          st;
    for (int k = 0; k < 24; k++) begin
      typ = 2'($urandom_range(0, 3));
      fn  = 7'($urandom_range(0, 127));
      d   = rnd36();
      st  = $urandom_range(0, 3);
      run_txn(typ, fn, d, st, 1'b0, '0);
      model_apply(typ, fn, d);
      n_checks++; if (o_timeout || o_lat !== exp_lat(typ)) begin n_fail++; $display("FAIL rnd%0d_latency type %0d: got %0d want %0d", k, typ, o_lat, exp_lat(typ)); end
      n_checks++; if (o_rsp !== exp_rsp(typ)) begin n_fail++; $display("FAIL rnd%0d_rsp type %0d: got %o want %o", k, typ, o_rsp, exp_rsp(typ)); end
      n_checks++; if (o_stb_cnt !== ((typ == 2'd1 || typ == 2'd2) ? T : 0)) begin n_fail++; $display("FAIL rnd%0d_strobe type %0d: got %0d cycles", k, typ, o_stb_cnt); end
      n_checks++; if (o_ds1 !== m_ds || o_drv1 !== m_drv || o_dout1 !== m_dout || o_busy1 !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_bus type %0d: ds %o drv %b dout %o busy %b want %o %b %o 1", k, typ, o_ds1, o_drv1, o_dout1, o_busy1, m_ds, m_drv, m_dout); end
      n_checks++; if (o_unstable || o_ds_moved || o_rdy_busy || o_valid_cycles !== st + 1 || o_post_ready !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_hs: unstable %b ds_moved %b rdy_busy %b valid %0d want %0d post_ready %b", k, o_unstable, o_ds_moved, o_rdy_busy, o_valid_cycles, st + 1, o_post_ready); end
    end
  endtask

  // Minimal timing instance: 1 setup, 1 strobe, no hold.
  task automatic test_short_timing();
    int lat, scnt, sfirst;
    logic [0:35] hist [0:15];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      r2_req_valid = 1'b1; r2_req_type = (k % 2 == 0) ? 2'd1 : 2'd2;
      r2_req_func = 7'($urandom_range(0, 127)); r2_req_data = rnd36(); r2_rsp_ready = 1'b1;
      r2_data_in = rnd36(); hist[0] = r2_data_in;
      @(posedge clk);
      lat = -1; scnt = 0; sfirst = -1;
      for (int j = 1; j < 15 && lat < 0; j++) begin
        @(negedge clk);
        r2_req_valid = 1'b0;
        if (r2_strobe === 1'b1) begin scnt++; if (sfirst < 0) sfirst = j; end
        if (r2_rsp_valid === 1'b1) lat = j;
        else begin r2_data_in = rnd36(); hist[j] = r2_data_in; end
      end
      n_checks++; if (lat !== 1 + S2 + T2 + H2) begin n_fail++; $display("FAIL short%0d_latency: got %0d want %0d", k, lat, 1 + S2 + T2 + H2); end
      n_checks++; if (scnt !== T2 || sfirst !== S2 + 1) begin n_fail++; $display("FAIL short%0d_strobe: width %0d first %0d want %0d %0d", k, scnt, sfirst, T2, S2 + 1); end
      if (lat > 0) begin
        n_checks++; if (r2_rsp_data !== hist[S2 + T2]) begin n_fail++; $display("FAIL short%0d_rsp: got %o want %o", k, r2_rsp_data, hist[S2 + T2]); end
      end
      @(negedge clk);
      n_checks++; if (r2_rsp_valid !== 1'b0 || r2_req_ready !== 1'b1) begin n_fail++; $display("FAIL short%0d_done: valid %b ready %b want 0 1", k, r2_rsp_valid, r2_req_ready); end
    end
    r2_rsp_ready = 1'b0;
  endtask

  initial begin
    req_valid = 1'b0; req_type = 2'd0; req_func = '0; req_data = '0; ebus_data_in = '0; rsp_ready = 1'b0;
    r2_req_valid = 1'b0; r2_req_type = 2'd0; r2_req_func = '0; r2_req_data = '0; r2_data_in = '0; r2_rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_release();
    test_diag_stall();
    test_reset_mid_strobe();
    test_back_to_back();
    test_held_during_write();
    test_random();
    test_short_timing();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
